// File: rtl/learning_key_encoder.sv
// Debounces seven note keys plus an octave toggle and encodes the held key
// into a registered 4-bit note value with a one-cycle press strobe.
//
// Optional feature: define KEY_SYNC_EN to add a two-flop synchronizer on
// every raw input ahead of the debouncers (adds two cycles of latency).
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive mismatching cycles needed to flip an input
//   CNT_W            debounce counter width
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   keys        raw note switches, bit 0 = do .. bit 6 = si, high = pressed
//   octave_btn  raw octave toggle button, high = pressed
//   note_value  0 = none, 1-7 base octave, 8-14 upper octave
//   key_valid   high while note_value is nonzero
//   key_press   one-cycle strobe when note_value changes to a nonzero value
//   octave      current octave, 0 = base, 1 = upper

module learning_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] keys,
    input  logic       octave_btn,
    output logic [3:0] note_value,
    output logic       key_valid,
    output logic       key_press,
    output logic       octave
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0] raw;
    logic [7:0] cond;

    assign raw = {octave_btn, keys};

`ifdef KEY_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign cond = sync2;
`else
    assign cond = raw;
`endif

    // Bit 7 of the debounced vector is the octave button.
    logic [7:0]       stable;
    logic [CNT_W-1:0] cnt [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cond[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= cond[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic       btn_prev;
    logic       oct_rise;
    logic       oct_next;
    logic [3:0] note_next;

    assign oct_rise = stable[7] & ~btn_prev;
    // The encoder sees the toggled octave on the same edge the octave
    // register flips, so a held key moves octave with no stale cycle.
    assign oct_next = octave ^ oct_rise;

    always_comb begin
        note_next = 4'd0;
        // Scan downward so the lowest held key is the last to assign.
        for (int i = 6; i >= 0; i--) begin
            if (stable[i]) begin
                note_next = 4'(i + 1) + (oct_next ? 4'd7 : 4'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev   <= 1'b0;
            octave     <= 1'b0;
            note_value <= 4'd0;
            key_valid  <= 1'b0;
            key_press  <= 1'b0;
        end else begin
            btn_prev   <= stable[7];
            octave     <= oct_next;
            note_value <= note_next;
            key_valid  <= (note_next != 4'd0);
            key_press  <= (note_next != note_value) && (note_next != 4'd0);
        end
    end

endmodule

// File: tb/tb_learning_key_encoder.sv
// Randomized scoreboard bench for learning_key_encoder (default build,
// inputs feed the debouncers directly).

module tb_learning_key_encoder;

    localparam int D = 4;

    typedef struct packed {
        logic [3:0] note;
        logic       valid;
        logic       press;
        logic       oct;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] keys;
    logic       octave_btn;
    logic [3:0] note_value;
    logic       key_valid;
    logic       key_press;
    logic       octave;

    always #5 clk = ~clk;

    learning_key_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keys(keys),
        .octave_btn(octave_btn),
        .note_value(note_value),
        .key_valid(key_valid),
        .key_press(key_press),
        .octave(octave)
    );

    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    exp_t sb[$];

    // Reference model: an input's clean value flips once the last D raw
    // samples taken since reset all disagree with it.
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic       m_btn_prev;
    logic       m_oct;
    logic [3:0] m_note;

    function automatic logic [3:0] encode(logic [6:0] k, logic o);
        for (int i = 0; i < 7; i++) begin
            if (k[i]) return 4'(i + 1 + 7 * int'(o));
        end
        return 4'd0;
    endfunction

    task automatic model_step(input logic [6:0] k, input logic b, input logic r);
        exp_t e;
        logic rise;
        logic no;
        logic [3:0] nn;
        logic [7:0] ns;
        if (r) begin
            hist.delete();
            m_stable   = '0;
            m_btn_prev = 1'b0;
            m_oct      = 1'b0;
            m_note     = 4'd0;
            e = '0;
        end else begin
            rise = m_stable[7] & ~m_btn_prev;
            no   = m_oct ^ rise;
            nn   = encode(m_stable[6:0], no);
            e.note  = nn;
            e.valid = (nn != 0);
            e.press = (nn != m_note) && (nn != 0);
            e.oct   = no;
            hist.push_back({b, k});
            if (hist.size() > D) void'(hist.pop_front());
            ns = m_stable;
            if (hist.size() == D) begin
                for (int i = 0; i < 8; i++) begin
                    bit all_diff = 1;
                    foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 0;
                    if (all_diff) ns[i] = ~m_stable[i];
                end
            end
            m_btn_prev = m_stable[7];
            m_stable   = ns;
            m_oct      = no;
            m_note     = nn;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic [6:0] k, input logic b, input logic r, input int n);
        for (int c = 0; c < n; c++) begin
            keys       = k;
            octave_btn = b;
            rst        = r;
            model_step(k, b, r);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] k;
        logic       b;
        // reset with every key held
        drive(7'h7F, 1'b0, 1'b1, 2);
        drive(7'h00, 1'b0, 1'b0, 3);
        // clean press and release
        drive(7'b0000100, 1'b0, 1'b0, 10);
        drive(7'h00, 1'b0, 1'b0, 10);
        // bounce rejection
        for (int p = 0; p < 5; p++) begin
            drive(7'h01, 1'b0, 1'b0, 3);
            drive(7'h00, 1'b0, 1'b0, 1);
        end
        // priority
        drive(7'b0100000, 1'b0, 1'b0, 8);
        drive(7'b0100010, 1'b0, 1'b0, 8);
        drive(7'b0100000, 1'b0, 1'b0, 8);
        // octave toggle twice with key held
        drive(7'b1000000, 1'b0, 1'b0, 8);
        drive(7'b1000000, 1'b1, 1'b0, 10);
        drive(7'b1000000, 1'b0, 1'b0, 8);
        drive(7'b1000000, 1'b1, 1'b0, 10);
        drive(7'b1000000, 1'b0, 1'b0, 8);
        // reset mid-debounce with key held
        drive(7'b0000100, 1'b0, 1'b0, 3);
        drive(7'b0000100, 1'b0, 1'b1, 1);
        drive(7'b0000100, 1'b0, 1'b0, 10);
        drive(7'h00, 1'b0, 1'b0, 8);
        // randomized segments
        for (int s = 0; s < 500; s++) begin
            case ($urandom_range(0, 3))
                0: k = 7'h00;
                1: k = 7'(1 << $urandom_range(0, 6));
                default: k = 7'($urandom);
            endcase
            b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0)
                drive(k, b, 1'b1, 1);
            else
                drive(k, b, 1'b0, $urandom_range(1, 10));
        end
        drive(7'h00, 1'b0, 1'b0, 10);
        done = 1;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (note_value !== e.note || key_valid !== e.valid ||
                    key_press !== e.press || octave !== e.oct) begin
                    errors++;
                    $display("FAIL cycle_check t=%0t got note=%0d valid=%b press=%b oct=%b want note=%0d valid=%b press=%b oct=%b",
                             $time, note_value, key_valid, key_press, octave,
                             e.note, e.valid, e.press, e.oct);
                end
            end else if (done) begin
                break;
            end
        end
        checks++;
        if (note_value !== 4'd0) begin
            errors++;
            $display("FAIL final_note got=%0d want=0", note_value);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_valid got=%b want=0", key_valid);
        end
        checks++;
        if (key_press !== 1'b0) begin
            errors++;
            $display("FAIL final_press got=%b want=0", key_press);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired checks=%0d want completion", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/learning_key_encoder.md
# learning_key_encoder

Front-end input stage of the piano's play/learning path. Debounces the seven note keys and an octave toggle button and encodes the held key into the 4-bit note value (0–15) consumed as `user_input` by the learning-mode block and by free-play. It emits a one-cycle press strobe whenever a new note starts, so the scorer can compare against the expected memory note.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000: consecutive cycles an input must differ from its stable value before the stable value flips (20 ms at 100 MHz); legal range 1 to 2^CNT_W−1.
- CNT_W, 21: debounce counter width.

Ports:
- clk  input  1  system clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- keys  input  7  raw note switches; bit 0 = do … bit 6 = si; high = pressed.
- octave_btn  input  1  raw octave toggle button, high = pressed.
- note_value  output  4  encoded note: 0 = none, 1–7 = base octave do–si, 8–14 = upper octave do–si; 15 is never driven.
- key_valid  output  1  high while note_value ≠ 0.
- key_press  output  1  one-cycle strobe when note_value changes to a nonzero value.
- octave  output  1  current octave: 0 = base, 1 = upper.

## Operation
- Input conditioning: eight raw inputs (keys, octave_btn) pass through the optional synchronizer (see Configuration), then through eight identical debouncers.
- Debouncer per input: register `stable` and counter `cnt`. Each cycle: if input == stable, cnt ← 0; else cnt ← cnt+1. When input ≠ stable and cnt == DEBOUNCE_CYCLES−1, stable ← input and cnt ← 0. A mismatch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged. The counter never wraps.
- Octave: on the cycle the debounced octave_btn goes 0→1, octave toggles. Button release has no effect. Holding the button gives no repeat.
- Encoding, priority: among debounced keys, the lowest set index i wins. Multiple held keys output the lowest note. The next value is 0 if no key is held, else i+1+7·octave.
- The next value is registered into note_value. key_valid = (note_value ≠ 0), registered together with note_value.
- key_press is high for one cycle when the registered note_value changes and the new value ≠ 0. This covers a new key, a switch between keys with no gap, and an octave toggle while a key is held. A change to 0 gives no strobe.

## Timing
- Reset, the cycle after rst is sampled high: note_value=0, key_valid=0, key_press=0, octave=0, all stable=0, all cnt=0, synchronizer flops=0.
- Reset mid-debounce discards the partial count. A key still held after reset is re-debounced from zero.
- Latency from a raw edge held steady to note_value/key_valid/key_press updating: S + DEBOUNCE_CYCLES + 1 clock edges. S = 2 with sync, 0 without.
- An octave press with a key held: octave and the updated note_value both appear S + DEBOUNCE_CYCLES + 1 edges after the button edge. key_press pulses on that same cycle.
- Simultaneous release of key i and press of key j: each debounces independently. note_value may pass through 0 or an intermediate value, and each nonzero change strobes key_press.

## Configuration
- KEY_SYNC_EN defined: each raw input goes through a two-flop synchronizer before debouncing (S = 2).
- KEY_SYNC_EN undefined: raw inputs feed the debouncers directly (S = 0). Use this only when inputs are already synchronous, e.g. in simulation.

## Test plan
- Reset: assert rst with keys=7'h7F held → next cycle note_value=0, key_valid=0, key_press=0, octave=0.
- Clean press (DEBOUNCE_CYCLES=4, KEY_SYNC_EN): keys=7'b0000100 from cycle 0 → note_value=3, key_valid=1 and a single key_press at cycle 7. Release → note_value=0 seven cycles later with no strobe.
- Bounce rejection: toggle keys[0] with 3-cycle high pulses separated by 1 low cycle, 5 times (DEBOUNCE_CYCLES=4) → note_value stays 0 and key_press never fires.
- Priority: hold keys[5] until debounced (note 6), then add keys[1] → note_value=2 with one key_press. Release keys[1] → note_value=6 with one key_press.
- Octave: hold keys[6] (note 7), press octave_btn for 10 cycles → octave=1, note_value=14, key_press once. A second press → octave=0, note_value=7.
- Reset mid-debounce: keys[2] high, rst pulsed at cycle 3, keys held → note_value=3 only DEBOUNCE_CYCLES+S+1 cycles after rst is deasserted.
